// File: rtl/int_wb_arbiter_pkg.sv
// Shared core types and default sizing for the integer writeback arbiter.
// comwbInfo_t is the per-FU result record carried from the ALU-class FUs to the regfile/ROB.
package int_wb_arbiter_pkg;

  localparam int INT_WB_NUM_FU     = 4;
  localparam int INT_WB_NUM_WBPORT = 2;

  localparam int ROB_IDX_W  = 6;
  localparam int IROB_IDX_W = 4;
  localparam int PRF_IDX_W  = 7;
  localparam int XLEN       = 64;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [IROB_IDX_W-1:0] irob_idx;
    logic                  use_imm;
    logic                  rd_wen;
    logic [PRF_IDX_W-1:0]  iprd_idx;
    logic [XLEN-1:0]       result;
  } comwbInfo_t;

  // Index width that stays legal (>= 1 bit) even for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_wb_arbiter_picker.sv
// Rotating multi-grant picker: scans req from ptr upward (mod NUM_FU) and hands the first
// NUM_WBPORT requesters to ports 0..NUM_WBPORT-1 in scan order. Purely combinational, no backpressure.
module rr_multi_picker
  import int_wb_arbiter_pkg::*;
#(
  parameter  int NUM_FU     = INT_WB_NUM_FU,
  parameter  int NUM_WBPORT = INT_WB_NUM_WBPORT,
  localparam int PTR_W      = idx_w(NUM_FU)
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] sel [NUM_WBPORT],
  output logic [NUM_FU-1:0] grant,
  output logic [PTR_W-1:0]  last_idx
);

  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;
  int               taken;

  always_comb begin
    for (int k = 0; k < NUM_WBPORT; k++) begin
      sel[k] = '0;
    end
    grant    = '0;
    last_idx = '0;
    taken    = 0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      // ptr + i never exceeds 2*NUM_FU-2, so one conditional subtract wraps it.
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_FU)) begin
        sum = sum - SUM_W'(NUM_FU);
      end
      idx = sum[PTR_W-1:0];
      if (req[idx] && (taken < NUM_WBPORT)) begin
        for (int k = 0; k < NUM_WBPORT; k++) begin
          if (k == taken) begin
            sel[k][idx] = 1'b1;
          end
        end
        grant[idx] = 1'b1;
        last_idx   = idx;
        taken      = taken + 1;
      end
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: NUM_FU results onto NUM_WBPORT ports, round-robin, 1-cycle latency;
// losers and all FUs under i_wb_block see o_wb_stall same cycle. WB_PERF_CNT_EN adds a conflict counter.
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = INT_WB_NUM_FU,
  parameter int NUM_WBPORT = INT_WB_NUM_WBPORT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FU-1:0]     i_fu_finished,
  input  comwbInfo_t            i_comwbInfo [NUM_FU],
  output logic [NUM_FU-1:0]     o_wb_stall,
  input  logic                  i_wb_block,
  output logic [NUM_WBPORT-1:0] o_wb_vld,
  output comwbInfo_t            o_wb_info [NUM_WBPORT],
  output logic [31:0]           o_perf_conflict_cnt
);

  localparam int PTR_W = idx_w(NUM_FU);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_ptr_nxt;
  logic [PTR_W-1:0]      last_idx;
  logic [NUM_FU-1:0]     req;
  logic [NUM_FU-1:0]     grant;
  logic [NUM_FU-1:0]     sel [NUM_WBPORT];
  logic [NUM_WBPORT-1:0] port_vld;
  comwbInfo_t            port_info [NUM_WBPORT];

  // A blocked downstream is modelled as "nobody requests", so the pointer naturally holds.
  assign req = i_wb_block ? '0 : i_fu_finished;

  rr_multi_picker #(
    .NUM_FU     (NUM_FU),
    .NUM_WBPORT (NUM_WBPORT)
  ) u_picker (
    .req      (req),
    .ptr      (rr_ptr),
    .sel      (sel),
    .grant    (grant),
    .last_idx (last_idx)
  );

  assign o_wb_stall = i_fu_finished & ~grant;

  always_comb begin
    port_vld = '0;
    for (int k = 0; k < NUM_WBPORT; k++) begin
      port_info[k] = '0;
      port_vld[k]  = |sel[k];
      for (int i = 0; i < NUM_FU; i++) begin
        if (sel[k][i]) begin
          port_info[k] = i_comwbInfo[i];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (|grant) begin
      rr_ptr_nxt = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      o_wb_vld <= '0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      o_wb_vld <= port_vld;
    end
  end

  // Payload is not reset; it only moves when its port is granted, otherwise it holds.
  for (genvar k = 0; k < NUM_WBPORT; k++) begin : g_port
    always_ff @(posedge clk) begin
      if (port_vld[k]) begin
        o_wb_info[k] <= port_info[k];
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_cnt;
  logic        conflict;

  assign conflict = (|o_wb_stall) & ~i_wb_block;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (conflict && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign o_perf_conflict_cnt = perf_cnt;
`else
  assign o_perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Bench for int_wb_arbiter: directed vector table, reset/perf sequences, then random traffic
// against a queue-based round-robin reference model.
module tb_int_wb_arbiter;
  import int_wb_arbiter_pkg::*;

  localparam int NF = INT_WB_NUM_FU;
  localparam int NW = INT_WB_NUM_WBPORT;
`ifdef WB_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] i_fu_finished;
  comwbInfo_t    i_comwbInfo [NF];
  logic [NF-1:0] o_wb_stall;
  logic          i_wb_block;
  logic [NW-1:0] o_wb_vld;
  comwbInfo_t    o_wb_info [NW];
  logic [31:0]   o_perf_conflict_cnt;

  int_wb_arbiter #(.NUM_FU(NF), .NUM_WBPORT(NW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_fu_finished       (i_fu_finished),
    .i_comwbInfo         (i_comwbInfo),
    .o_wb_stall          (o_wb_stall),
    .i_wb_block          (i_wb_block),
    .o_wb_vld            (o_wb_vld),
    .o_wb_info           (o_wb_info),
    .o_perf_conflict_cnt (o_perf_conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic comwbInfo_t mk_info(input int fu, input logic [63:0] base);
    comwbInfo_t r;
    r.rob_idx  = ROB_IDX_W'(fu + 1);
    r.irob_idx = IROB_IDX_W'(fu);
    r.use_imm  = fu[0];
    r.rd_wen   = 1'b1;
    r.iprd_idx = PRF_IDX_W'(fu + 8);
    r.result   = base + 64'(fu);
    return r;
  endfunction

  task automatic drive(input logic [NF-1:0] fin, input logic blk, input logic [63:0] base);
    i_fu_finished = fin;
    i_wb_block    = blk;
    for (int i = 0; i < NF; i++) i_comwbInfo[i] = mk_info(i, base);
  endtask

  typedef struct {
    logic [NF-1:0] fin;
    logic          blk;
    logic [63:0]   base;
    logic [NF-1:0] stall;
    logic [NW-1:0] vld;
    int            p0;
    int            p1;
  } vec_t;

  vec_t vt [11];

  // Reference model state
  int            mptr;
  int            mperf;
  logic [NF-1:0] pend;
  comwbInfo_t    minfo [NF];
  comwbInfo_t    mport [NW];
  bit            mknown [NW];
  int            waitc [NF];
  int            g [$];
  logic [NF-1:0] es;
  logic [NW-1:0] ev;
  logic          rblk;
  bit            starved;

  initial begin
    // ptr trail: 0 ->1 ->1 ->0 ->2 ->0 ->3 ->1 ->1(blocked) ->3 ->2 ->1
    vt[0]  = '{4'b0001, 1'b0, 64'h5,    4'b0000, 2'b01, 0, -1};
    vt[1]  = '{4'b0000, 1'b0, 64'h100,  4'b0000, 2'b00, -1, -1};
    vt[2]  = '{4'b1000, 1'b0, 64'h200,  4'b0000, 2'b01, 3, -1};
    vt[3]  = '{4'b1111, 1'b0, 64'h300,  4'b1100, 2'b11, 0, 1};
    vt[4]  = '{4'b1100, 1'b0, 64'h400,  4'b0000, 2'b11, 2, 3};
    vt[5]  = '{4'b0100, 1'b0, 64'h500,  4'b0000, 2'b01, 2, -1};
    vt[6]  = '{4'b1001, 1'b0, 64'h600,  4'b0000, 2'b11, 3, 0};
    vt[7]  = '{4'b0110, 1'b1, 64'h700,  4'b0110, 2'b00, -1, -1};
    vt[8]  = '{4'b0110, 1'b0, 64'h800,  4'b0000, 2'b11, 1, 2};
    vt[9]  = '{4'b0111, 1'b0, 64'h900,  4'b0100, 2'b11, 0, 1};
    vt[10] = '{4'b0101, 1'b0, 64'hA00,  4'b0000, 2'b11, 2, 0};

    rst = 1'b1;
    drive('0, 1'b0, 64'h0);
    @(posedge clk); #1;
    chk("reset_vld", o_wb_vld, '0);
    chk("reset_perf", o_perf_conflict_cnt, 32'd0);
    chk("reset_stall", o_wb_stall, '0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      drive(vt[v].fin, vt[v].blk, vt[v].base);
      #1 chk($sformatf("vec%0d_stall", v), o_wb_stall, vt[v].stall);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_vld", v), o_wb_vld, vt[v].vld);
      if (vt[v].p0 >= 0) chk($sformatf("vec%0d_port0", v), o_wb_info[0].result, vt[v].base + 64'(vt[v].p0));
      if (vt[v].p1 >= 0) chk($sformatf("vec%0d_port1", v), o_wb_info[1].result, vt[v].base + 64'(vt[v].p1));
    end
    chk("table_perf", o_perf_conflict_cnt, PERF_ON ? 32'd2 : 32'd0);

    // Reset pulses between clock edges
    @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
    drive(4'b1111, 1'b0, 64'h40);
    #1 chk("rs_a_stall", o_wb_stall, 4'b1100);
    @(posedge clk); #1 chk("rs_a_vld", o_wb_vld, 2'b11);
    @(negedge clk);
    drive(4'b1111, 1'b0, 64'h50);
    #1 chk("rs_b_stall_ptr2", o_wb_stall, 4'b0011);
    #1 rst = 1'b1;
    #1 chk("rs_b_async_vld", o_wb_vld, 2'b00);
    rst = 1'b0;
    #1 chk("rs_b_ptr_zero", o_wb_stall, 4'b1100);
    @(posedge clk); #1;
    chk("rs_b_vld", o_wb_vld, 2'b11);
    chk("rs_b_port0", o_wb_info[0].result, 64'h50);
    chk("rs_b_port1", o_wb_info[1].result, 64'h51);
    @(negedge clk); drive(4'b1100, 1'b0, 64'h60);
    @(negedge clk); drive(4'b1111, 1'b0, 64'h70);
    #1 chk("rs_c_stall", o_wb_stall, 4'b1100);
    chk("rs_c_vld_before", o_wb_vld, 2'b11);
    #1 rst = 1'b1;
    #1 chk("rs_c_async_vld", o_wb_vld, 2'b00);
    chk("rs_c_perf", o_perf_conflict_cnt, 32'd0);
    rst = 1'b0;

    // Perf: three conflict cycles then one blocked cycle
    @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(4'b1111, 1'b0, 64'h80);
    end
    @(negedge clk); drive(4'b1111, 1'b1, 64'h90);
    @(negedge clk); drive('0, 1'b0, 64'h0);
    #1 chk("perf_3_conflicts", o_perf_conflict_cnt, PERF_ON ? 32'd3 : 32'd0);

    // Random traffic with held results against the reference model
    @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
    mptr = 0; mperf = 0; pend = '0;
    for (int k = 0; k < NW; k++) mknown[k] = 1'b0;
    for (int i = 0; i < NF; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NF; i++) begin
        if (!pend[i]) begin
          pend[i]  = ($urandom_range(0, 99) < 60);
          minfo[i] = mk_info(i, {$urandom, $urandom});
        end
      end
      rblk = ($urandom_range(0, 9) == 0);
      i_fu_finished = pend;
      i_wb_block    = rblk;
      for (int i = 0; i < NF; i++) i_comwbInfo[i] = minfo[i];

      g.delete();
      if (!rblk) begin
        for (int s = 0; s < NF; s++) begin
          if (pend[(mptr + s) % NF] && g.size() < NW) g.push_back((mptr + s) % NF);
        end
      end
      es = pend;
      ev = '0;
      foreach (g[k]) begin
        es[g[k]] = 1'b0;
        ev[k]    = 1'b1;
      end
      #1 chk("rand_stall", o_wb_stall, es);

      starved = 1'b0;
      for (int i = 0; i < NF; i++) begin
        if (!o_wb_stall[i]) waitc[i] = 0;
        else if (!rblk) waitc[i]++;
        if (waitc[i] > (NF + NW - 1) / NW - 1) starved = 1'b1;
      end
      chk("rand_starvation", starved, 1'b0);

      if (!rblk && es != '0) mperf++;
      if (g.size() > 0) mptr = (g[g.size() - 1] + 1) % NF;
      foreach (g[k]) begin
        mport[k]  = minfo[g[k]];
        mknown[k] = 1'b1;
        pend[g[k]] = 1'b0;
      end

      @(posedge clk); #1;
      chk("rand_vld", o_wb_vld, ev);
      for (int k = 0; k < NW; k++) begin
        if (mknown[k]) chk($sformatf("rand_info%0d", k), o_wb_info[k], mport[k]);
      end
    end
    chk("rand_perf", o_perf_conflict_cnt, PERF_ON ? 32'(mperf) : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
